// File: rtl/multiplier2x2_divider_if.sv
// Request/response bundle for the iterative divider: operands and start in,
// busy/done handshake and results out.
interface multiplier2x2_divider_if #(
  parameter int N = 2
);
  logic             i_start;
  logic [2*N-1:0]   i_dividend;
  logic [N-1:0]     i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [2*N-1:0]   o_quotient;
  logic [N-1:0]     o_remainder;
  logic             o_overflow;
  logic             o_div_by_zero;

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder, o_overflow, o_div_by_zero
  );

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder, o_overflow, o_div_by_zero
  );
endinterface

// File: rtl/multiplier2x2_divider.sv
// Unsigned restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, start/busy/done handshake and registered results.
module multiplier2x2_divider #(
  parameter int N = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  multiplier2x2_divider_if.slave bus
);
  localparam int KW = (2 * N > 1) ? $clog2(2 * N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [2*N-1:0]  r_q;
  logic [N-1:0]    r_d;
  logic [N:0]      r_r;
  logic [KW-1:0]   r_k;
  logic            r_zero;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;
  logic            r_dbz;
  logic [2*N-1:0]  r_quot;
  logic [N-1:0]    r_rem;

  logic [N:0]      w_r_shift;
  logic            w_ge;
  logic [N:0]      w_r_next;
  logic [2*N-1:0]  w_q_next;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_r_shift = {r_r[N-1:0], r_q[2*N-1]};
  assign w_ge      = (w_r_shift >= {1'b0, r_d});
  assign w_r_next  = w_ge ? (w_r_shift - {1'b0, r_d}) : w_r_shift;
  assign w_q_next  = {r_q[2*N-2:0], w_ge};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_k     <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            r_q     <= bus.i_dividend;
            r_d     <= bus.i_divisor;
            r_r     <= '0;
            r_k     <= KW'(2 * N - 1);
            r_zero  <= (bus.i_divisor == '0);
            r_busy  <= 1'b1;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // A zero divisor spends a single busy cycle, then reports saturated results.
          if (r_zero) begin
            r_quot  <= '1;
            r_rem   <= r_q[N-1:0];
            r_ovf   <= 1'b1;
            r_dbz   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            r_k <= r_k - 1'b1;
            if (r_k == '0) begin
              r_quot  <= w_q_next;
              r_rem   <= w_r_next[N-1:0];
              r_ovf   <= |w_q_next[2*N-1:N];
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_quotient    = r_quot;
  assign bus.o_remainder   = r_rem;
  assign bus.o_overflow    = r_ovf;
  assign bus.o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_multiplier2x2_divider.sv
// Scoreboard bench for the divider: the driver queues arithmetic expectations,
// the monitor checks every done pulse against them, including its cycle.
module tb_multiplier2x2_divider;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier2x2_divider_if #(.N(N)) ifc ();

  multiplier2x2_divider #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int ovf;
    int dbz;
    int cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer division with the zero-divisor convention.
  function automatic exp_t model(input int dvd, input int dvs, input int accept_cyc);
    exp_t e;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 0) begin
      e.q   = (1 << (2 * N)) - 1;
      e.r   = dvd % (1 << N);
      e.ovf = 1;
      e.dbz = 1;
      e.cyc = accept_cyc + 1;
    end else begin
      e.q   = dvd / dvs;
      e.r   = dvd % dvs;
      e.ovf = (e.q >= (1 << N)) ? 1 : 0;
      e.dbz = 0;
      e.cyc = accept_cyc + 2 * N;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input int dvd, input int dvs, input bit keep);
    int guard = 0;
    while (ifc.o_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("issue_wait_timeout", 1, 0);
    ifc.i_start    = 1'b1;
    ifc.i_dividend = (2*N)'(dvd);
    ifc.i_divisor  = N'(dvs);
    sb.push_back(model(dvd, dvs, cyc + 1));
    @(negedge clk);
    if (!keep) ifc.i_start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (ifc.o_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("div %0d/%0d -> q=%0d r=%0d ovf=%0b dbz=%0b at cycle %0d",
                 e.dvd, e.dvs, ifc.o_quotient, ifc.o_remainder,
                 ifc.o_overflow, ifc.o_div_by_zero, cyc);
        chk("done_cycle", cyc, e.cyc);
        chk("quotient", int'(ifc.o_quotient), e.q);
        chk("remainder", int'(ifc.o_remainder), e.r);
        chk("overflow", int'(ifc.o_overflow), e.ovf);
        chk("div_by_zero", int'(ifc.o_div_by_zero), e.dbz);
        chk("busy_at_done", int'(ifc.o_busy), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(ifc.o_busy), 0);
    chk({tag, "_done"}, int'(ifc.o_done), 0);
    chk({tag, "_quotient"}, int'(ifc.o_quotient), 0);
    chk({tag, "_remainder"}, int'(ifc.o_remainder), 0);
    chk({tag, "_overflow"}, int'(ifc.o_overflow), 0);
    chk({tag, "_div_by_zero"}, int'(ifc.o_div_by_zero), 0);
  endtask

  initial begin
    int cnt;
    ifc.i_start    = 1'b0;
    ifc.i_dividend = '0;
    ifc.i_divisor  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle");

    // 9 / 3 with busy-width check
    issue(9, 3, 1'b0);
    cnt = 0;
    repeat (6) begin
      if (ifc.o_busy) cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, 2 * N);
    drain();

    // Inverse of every product, plus the two called-out cases
    for (int a = 0; a < 4; a++)
      for (int b = 1; b < 4; b++)
        issue(a * b, b, 1'b0);
    issue(7, 2, 1'b0);
    issue(15, 1, 1'b0);
    drain();

    // Divide by zero, then a valid division clears the flags at accept
    issue(6, 0, 1'b0);
    chk("dbz_busy_one_cycle", int'(ifc.o_busy), 1);
    @(negedge clk);
    chk("dbz_busy_dropped", int'(ifc.o_busy), 0);
    drain();
    issue(6, 3, 1'b0);
    chk("flag_clear_dbz", int'(ifc.o_div_by_zero), 0);
    chk("flag_clear_ovf", int'(ifc.o_overflow), 0);
    drain();

    // Start while busy must be ignored
    issue(14, 3, 1'b0);
    @(negedge clk);
    ifc.i_start    = 1'b1;
    ifc.i_dividend = 4'd1;
    ifc.i_divisor  = 2'd1;
    @(negedge clk);
    ifc.i_start = 1'b0;
    drain();

    // Back-to-back with start held high
    issue(12, 2, 1'b1);
    cnt = 0;
    while (!ifc.o_done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first_done_seen", int'(ifc.o_done), 1);
    issue(13, 3, 1'b0);
    drain();

    // Asynchronous reset in the middle of 11 / 2
    issue(11, 2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_done", int'(ifc.o_done), 0);
    issue(11, 2, 1'b0);
    drain();

    // Random operands, issued as fast as the handshake allows
    for (int i = 0; i < 40; i++)
      issue(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)), 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
